// File: rtl/return_stack_if.sv
// return_stack_if: CALL/RET request and stack-status bundle between control logic and the return stack
interface return_stack_if #(
  parameter int ADDR_W = 8,
  parameter int DEPTH_LOG2 = 5
);
  logic push;
  logic pop;
  logic clear_err;
  logic [ADDR_W-1:0] push_data;
  logic [ADDR_W-1:0] top;
  logic [DEPTH_LOG2-1:0] sp;
  logic empty;
  logic full;
  logic overflow;
  logic underflow;
  modport master (
    output push, pop, clear_err, push_data,
    input top, sp, empty, full, overflow, underflow
  );
  modport slave (
    input push, pop, clear_err, push_data,
    output top, sp, empty, full, overflow, underflow
  );
endinterface

// File: rtl/return_stack.sv
// return_stack: registered return-address stack with registered top-of-stack and sticky misuse flags
module return_stack #(
  parameter int ADDR_W = 8,
  parameter int DEPTH_LOG2 = 5
) (
  input logic clk,
  input logic reset,
  return_stack_if.slave bus
);
  logic [ADDR_W-1:0] mem [2**DEPTH_LOG2];
  logic push_eff, pop_eff, ovf_hit, unf_hit;
  logic [DEPTH_LOG2-1:0] sp_n, wr_addr;
  logic [ADDR_W-1:0] top_n;
  assign bus.empty = bus.sp == '0;
  assign bus.full = bus.sp == '1;
  assign push_eff = bus.push & ~(bus.full & ~bus.pop);
  assign pop_eff = bus.pop & ~bus.empty;
  assign ovf_hit = bus.push & bus.full & ~bus.pop;
  assign unf_hit = bus.pop & bus.empty;
  assign sp_n = bus.sp + DEPTH_LOG2'(push_eff) - DEPTH_LOG2'(pop_eff);
  // A push paired with a real pop overwrites the current top slot instead of the next free one
  assign wr_addr = pop_eff ? bus.sp - DEPTH_LOG2'(1) : bus.sp;
  always_comb
    top_n = push_eff ? bus.push_data
          : pop_eff ? (bus.sp >= DEPTH_LOG2'(2) ? mem[bus.sp - DEPTH_LOG2'(2)] : '0)
          : bus.top;
  always_ff @(posedge clk)
    if (push_eff) mem[wr_addr] <= bus.push_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.sp <= '0;
      bus.top <= '0;
      bus.overflow <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      bus.sp <= sp_n;
      bus.top <= top_n;
      bus.overflow <= ovf_hit | (bus.overflow & ~bus.clear_err);
      bus.underflow <= unf_hit | (bus.underflow & ~bus.clear_err);
    end
endmodule

// File: tb/tb_return_stack.sv
// tb_return_stack: directed self-checking bench for the return-address stack
module tb_return_stack;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errs = 0;
  int checks = 0;
  return_stack_if #(.ADDR_W(8), .DEPTH_LOG2(5)) bus ();
  return_stack #(.ADDR_W(8), .DEPTH_LOG2(5)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic p, input logic po, input logic [7:0] d, input logic ce);
    @(negedge clk);
    bus.push = p;
    bus.pop = po;
    bus.push_data = d;
    bus.clear_err = ce;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_state(input string tag, input logic [4:0] esp, input logic [7:0] etop);
    chk({tag, ".sp"}, 32'(bus.sp), 32'(esp));
    chk({tag, ".top"}, 32'(bus.top), 32'(etop));
  endtask
  initial begin
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.push_data = '0;
    bus.clear_err = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk_state("rst_async", 5'd0, 8'h00);
    chk("rst_async.empty", 32'(bus.empty), 32'd1);
    chk("rst_async.full", 32'(bus.full), 32'd0);
    chk("rst_async.ovf", 32'(bus.overflow), 32'd0);
    chk("rst_async.unf", 32'(bus.underflow), 32'd0);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 0);
    chk_state("idle", 5'd0, 8'h00);
    chk("idle.empty", 32'(bus.empty), 32'd1);
    chk("idle.flags", 32'({bus.overflow, bus.underflow}), 32'd0);
    step(1, 0, 8'h11, 0);
    chk_state("push1", 5'd1, 8'h11);
    chk("push1.empty", 32'(bus.empty), 32'd0);
    step(1, 0, 8'h22, 0);
    step(1, 0, 8'h33, 0);
    chk_state("push3", 5'd3, 8'h33);
    step(0, 1, 8'h00, 0);
    chk_state("pop1", 5'd2, 8'h22);
    step(0, 1, 8'h00, 0);
    chk_state("pop2", 5'd1, 8'h11);
    step(0, 1, 8'h00, 0);
    chk_state("pop3", 5'd0, 8'h00);
    chk("pop3.empty", 32'(bus.empty), 32'd1);
    chk("pop3.unf", 32'(bus.underflow), 32'd0);
    for (int i = 1; i < 32; i++) step(1, 0, 8'(i), 0);
    chk_state("fill", 5'd31, 8'd31);
    chk("fill.full", 32'(bus.full), 32'd1);
    chk("fill.ovf", 32'(bus.overflow), 32'd0);
    step(1, 0, 8'hAA, 0);
    chk_state("ovf", 5'd31, 8'd31);
    chk("ovf.flag", 32'(bus.overflow), 32'd1);
    step(0, 1, 8'h00, 0);
    chk_state("ovf_pop", 5'd30, 8'd30);
    chk("ovf_pop.flag", 32'(bus.overflow), 32'd1);
    chk("ovf_pop.full", 32'(bus.full), 32'd0);
    step(0, 0, 8'h00, 1);
    chk("ovf_clr", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 30; i++) step(0, 1, 8'h00, 0);
    chk_state("drain", 5'd0, 8'h00);
    chk("drain.unf", 32'(bus.underflow), 32'd0);
    step(0, 1, 8'h00, 0);
    chk_state("unf", 5'd0, 8'h00);
    chk("unf.flag", 32'(bus.underflow), 32'd1);
    step(1, 1, 8'h5C, 0);
    chk_state("unf_pp", 5'd1, 8'h5C);
    chk("unf_pp.flag", 32'(bus.underflow), 32'd1);
    step(0, 0, 8'h00, 1);
    chk("unf_clr", 32'(bus.underflow), 32'd0);
    chk_state("unf_clr", 5'd1, 8'h5C);
    step(0, 1, 8'h00, 0);
    chk_state("rep_pre", 5'd0, 8'h00);
    step(1, 0, 8'h40, 0);
    step(1, 0, 8'h41, 0);
    step(1, 1, 8'h99, 0);
    chk_state("replace", 5'd2, 8'h99);
    chk("replace.flags", 32'({bus.overflow, bus.underflow}), 32'd0);
    step(0, 1, 8'h00, 0);
    chk_state("rep_pop", 5'd1, 8'h40);
    step(0, 1, 8'h00, 0);
    chk_state("rep_pop2", 5'd0, 8'h00);
    for (int i = 1; i < 32; i++) step(1, 0, 8'(8'h80 + i), 0);
    chk_state("refill", 5'd31, 8'h9F);
    step(1, 1, 8'h77, 0);
    chk_state("full_rep", 5'd31, 8'h77);
    chk("full_rep.ovf", 32'(bus.overflow), 32'd0);
    step(0, 1, 8'h00, 0);
    chk_state("full_rep_pop", 5'd30, 8'h9E);
    step(1, 0, 8'h9F, 0);
    step(1, 0, 8'hAB, 0);
    chk("ovf2", 32'(bus.overflow), 32'd1);
    step(1, 0, 8'hAC, 1);
    chk("setwins.ovf", 32'(bus.overflow), 32'd1);
    chk_state("setwins", 5'd31, 8'h9F);
    step(0, 0, 8'h00, 1);
    chk("clr_only", 32'(bus.overflow), 32'd0);
    step(0, 0, 8'h00, 0);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk_state("rst_mid", 5'd0, 8'h00);
    chk("rst_mid.empty", 32'(bus.empty), 32'd1);
    #1 reset = 1'b0;
    step(0, 0, 8'h00, 0);
    chk_state("rst_mid_hold", 5'd0, 8'h00);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/return_stack.md
Name: return_stack

Overview:
- Registered return-address stack for CALL/RET in the Harvard CPU.
- Consumes the next-pointer arithmetic s + push − pop and holds the current pointer in a register, feeding it back each cycle.
- Stores return addresses in a 32-slot array and presents the top-of-stack address, registered, to the PC-select mux.
- Flags misuse (push when full, pop when empty) so control logic can trap.

Parameters:
- ADDR_W, 8, width of a stored return address (PC width).
- DEPTH_LOG2, 5, pointer width. Slot count is 2**DEPTH_LOG2 = 32; usable capacity is 31 entries.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- push  input  1  CALL: write push_data onto the stack this cycle.
- pop  input  1  RET: remove the top entry this cycle.
- push_data  input  ADDR_W  return address to store (PC+1 from fetch).
- clear_err  input  1  synchronous clear of the overflow/underflow sticky flags.
- top  output  ADDR_W  registered top-of-stack value; 0 when empty.
- sp  output  DEPTH_LOG2  registered stack pointer (next free slot = entry count).
- empty  output  1  sp == 0.
- full  output  1  sp == 31.
- overflow  output  1  sticky: push was attempted while full.
- underflow  output  1  sticky: pop was attempted while empty.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - sp = 0, top = 0, overflow = 0, underflow = 0; empty = 1, full = 0.
  - Array contents are not reset and are don't-care.
- Storage: mem[0..31], each ADDR_W bits wide.
  - Valid entries are mem[0..sp−1]; the top entry is mem[sp−1].
- Effective requests:
  - push_eff = push & ~(full & ~pop)
  - pop_eff = pop & ~empty
- Next pointer: sp_n = sp + push_eff − pop_eff, computed mod 32 in DEPTH_LOG2 bits. It never wraps because the qualifications above block it.
- Cycle actions, evaluated each rising edge:
  - push only, not full: mem[sp] <= push_data; sp <= sp+1; top <= push_data.
  - push only, full (sp=31): nothing written; sp and top unchanged; overflow <= 1.
  - pop only, not empty: sp <= sp−1; top <= mem[sp−2] if sp ≥ 2, else 0.
  - pop only, empty: sp unchanged; top stays 0; underflow <= 1.
  - push and pop, not empty (full included): replace top. mem[sp−1] <= push_data; sp unchanged; top <= push_data; no flag set.
  - push and pop, empty: pop is ignored and underflow <= 1; push executes (mem[0] <= push_data, sp <= 1, top <= push_data).
  - neither: hold all state.
- Latency: top, sp, empty and full reflect a request one cycle after the edge that samples it. top never combinationally depends on push or pop.
- clear_err clears both sticky flags. If a new violation occurs in the same cycle as clear_err, the flag is set (set wins).
- empty and full are decoded from the registered sp, so they have no extra latency.
- mem read and write in the same cycle never target the same slot, except in the replace case, where top takes push_data directly.

Test Plan:
- Reset then idle: assert reset mid-cycle, release -> sp=0, top=0, empty=1, flags 0 immediately (asynchronous), and they hold over 5 idle cycles.
- LIFO order: push 0x11, 0x22, 0x33, then pop ×3.
  - After the pushes: top=0x33, sp=3.
  - After each pop: top=0x22/sp=2, then 0x11/sp=1, then 0x00/sp=0 with empty=1.
- Fill and overflow: push values 1..31 -> full=1, sp=31, top=31. A 32nd push of 0xAA -> sp=31, top=31, overflow=1. Then pop -> top=30, overflow stays 1 until clear_err.
- Underflow: from empty, pop -> underflow=1, sp=0. Then push+pop of 0x5C -> sp=1, top=0x5C, underflow=1. Then clear_err -> underflow=0.
- Replace top: push 0x40, 0x41, then push+pop of 0x99 -> sp=2, top=0x99. Pop -> top=0x40.
- Set-wins: while full, push with clear_err=1 -> overflow=1 the next cycle.
